// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters. Predicts in IF,
// trains from resolved EX outcomes, and flags mispredicts with the correct redirect PC.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            bp_clear,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]    r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [31:0]        r_branch_cnt;
    logic [31:0]        r_mispred_cnt;

    logic [IDX-1:0]  w_if_idx;
    logic [TAGW-1:0] w_if_tag;
    logic            w_if_hit;
    logic [IDX-1:0]  w_ex_idx;
    logic [TAGW-1:0] w_ex_tag;
    logic            w_ex_hit;
    logic            w_update;
    logic            w_alloc;
    logic            w_train;
    logic            w_dir_wrong;
    logic            w_tgt_wrong;
    logic            w_nonbr_wrong;
    logic [1:0]      w_ctr_cur;
    logic [1:0]      w_ctr_next;

    // Fetch-side lookup reads registered state only, so a same-cycle EX write is not bypassed.
    assign w_if_idx    = if_pc[IDX+1:2];
    assign w_if_tag    = if_pc[XLEN-1:IDX+2];
    assign w_if_hit    = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = w_if_hit & r_ctr[w_if_idx][1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + XLEN'(4);

    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX+2];
    assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    assign w_update = ex_valid & (ex_branch | ex_jump);
    assign w_alloc  = w_update & ~w_ex_hit & ex_taken;
    assign w_train  = w_update & w_ex_hit;

    assign w_ctr_cur = r_ctr[w_ex_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (ex_taken) begin
            if (w_ctr_cur != 2'b11) begin
                w_ctr_next = w_ctr_cur + 2'b01;
            end
        end else begin
            if (w_ctr_cur != 2'b00) begin
                w_ctr_next = w_ctr_cur - 2'b01;
            end
        end
    end

    assign w_dir_wrong   = ex_taken != ex_pred_taken;
    assign w_tgt_wrong   = ex_taken & (ex_target != ex_pred_target);
    // A non-control instruction that fetch redirected must be steered back to pc+4.
    assign w_nonbr_wrong = ex_valid & ~ex_branch & ~ex_jump & ex_pred_taken;
    assign mispredict    = (w_update & (w_dir_wrong | w_tgt_wrong)) | w_nonbr_wrong;
    assign redirect_pc   = (w_update & ex_taken) ? ex_target : ex_pc + XLEN'(4);

    // bp_clear has priority over any allocation or training in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp_clear) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
            r_ctr[w_ex_idx]    <= ex_jump ? 2'b11 : 2'b10;
        end else if (w_train) begin
            r_ctr[w_ex_idx] <= w_ctr_next;
            if (ex_taken) begin
                r_target[w_ex_idx] <= ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_update) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized bench for branch_predictor, checked against a table model
// that applies the predictor's rules with plain integer arithmetic.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int XLEN    = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            bp_clear;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .XLEN    (XLEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .bp_clear       (bp_clear),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: per-slot valid/tag/target plus counter as an int in 0..3.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    logic        obs_pt;
    logic [31:0] obs_ptgt;
    logic        obs_mp;
    logic [31:0] obs_redir;
    logic [31:0] obs_bcnt;
    logic [31:0] obs_mcnt;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / (4 * ENTRIES));
    endfunction

    task automatic m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        t   = m_hit(pc) && (m_ctr[slot(pc)] >= 2);
        tgt = t ? m_target[slot(pc)] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    // One clock: drive at negedge, compare combinational outputs, then apply the model update.
    task automatic cyc(input logic [31:0] ipc, input bit v, input logic [31:0] epc,
                       input bit br, input bit jp, input bit tk, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt, input bit clr);
        bit          e_pt;
        logic [31:0] e_ptgt;
        bit          upd;
        bit          e_mp;
        bit          hit;
        int          s;
        @(negedge clk);
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_branch = br; ex_jump = jp;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        bp_clear = clr;
        #1;
        m_predict(ipc, e_pt, e_ptgt);
        upd  = v && (br || jp);
        e_mp = (upd && ((tk != ptk) || (tk && tgt != ptgt))) || (v && !br && !jp && ptk);
        obs_pt = pred_taken; obs_ptgt = pred_target; obs_mp = mispredict;
        obs_redir = redirect_pc; obs_bcnt = branch_cnt; obs_mcnt = mispred_cnt;
        check("pred_taken", {31'd0, obs_pt}, {31'd0, e_pt});
        check("pred_target", obs_ptgt, e_ptgt);
        check("mispredict", {31'd0, obs_mp}, {31'd0, e_mp});
        check("redirect_pc", obs_redir, (upd && tk) ? tgt : epc + 32'd4);
        check("branch_cnt", obs_bcnt, m_bcnt);
        check("mispred_cnt", obs_mcnt, m_mcnt);
        @(posedge clk);
        hit = m_hit(epc);
        s   = slot(epc);
        if (clr) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (upd && hit) begin
            m_ctr[s] = tk ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                          : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
            if (tk) m_target[s] = tgt;
        end else if (upd && tk) begin
            m_valid[s]  = 1'b1;
            m_tag[s]    = epc / (4 * ENTRIES);
            m_target[s] = tgt;
            m_ctr[s]    = jp ? 3 : 2;
        end
        if (upd) m_bcnt = m_bcnt + 32'd1;
        if (e_mp) m_mcnt = m_mcnt + 32'd1;
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(ipc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    logic [31:0] r_ipc, r_epc, r_tgt, r_ptgt, saved_bcnt;
    bit          r_v, r_br, r_jp, r_tk, r_ptk, r_clr;
    int          kind;

    initial begin
        m_reset();
        if_pc = 32'h100; ex_valid = 0; ex_pc = 0; ex_branch = 0; ex_jump = 0; ex_taken = 0;
        ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0; bp_clear = 0;
        #12;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(32'h100);
        check("cold_pt", {31'd0, obs_pt}, 32'd0);
        check("cold_tgt", obs_ptgt, 32'h104);

        cyc(32'h0, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
        check("alloc_mp", {31'd0, obs_mp}, 32'd1);
        check("alloc_redir", obs_redir, 32'h80);
        idle(32'h100);
        check("alloc_pt", {31'd0, obs_pt}, 32'd1);
        check("alloc_tgt", obs_ptgt, 32'h80);
        check("alloc_mcnt", obs_mcnt, 32'd1);

        repeat (4) cyc(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0);
        cyc(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
        check("sat_nt1_mp", {31'd0, obs_mp}, 32'd1);
        check("sat_nt1_redir", obs_redir, 32'h104);
        idle(32'h100);
        check("sat_still_taken", {31'd0, obs_pt}, 32'd1);
        cyc(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
        check("sat_nt2_mp", {31'd0, obs_mp}, 32'd1);
        check("sat_nt2_redir", obs_redir, 32'h104);
        idle(32'h100);
        check("sat_now_nt", {31'd0, obs_pt}, 32'd0);
        check("sat_now_tgt", obs_ptgt, 32'h104);

        cyc(32'h100, 1, 32'h140, 1, 0, 1, 32'h300, 0, 32'h144, 0);
        idle(32'h100);
        check("alias_old_pt", {31'd0, obs_pt}, 32'd0);
        check("alias_old_tgt", obs_ptgt, 32'h104);
        idle(32'h140);
        check("alias_new_tgt", obs_ptgt, 32'h300);

        saved_bcnt = m_bcnt;
        cyc(32'h0, 1, 32'h200, 0, 0, 0, 32'h0, 1, 32'h300, 0);
        check("nonbr_mp", {31'd0, obs_mp}, 32'd1);
        check("nonbr_redir", obs_redir, 32'h204);
        idle(32'h0);
        check("nonbr_bcnt", obs_bcnt, saved_bcnt);

        cyc(32'h140, 1, 32'h180, 1, 0, 1, 32'h40, 0, 32'h184, 1);
        idle(32'h180);
        check("clr_alloc_pt", {31'd0, obs_pt}, 32'd0);
        idle(32'h140);
        check("clr_old_pt", {31'd0, obs_pt}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            r_ipc = 32'h100 + ($urandom_range(0, 31) << 2);
            r_epc = 32'h100 + ($urandom_range(0, 31) << 2);
            kind  = int'($urandom_range(0, 9));
            r_br  = kind < 6;
            r_jp  = (kind == 6) || (kind == 7);
            r_v   = $urandom_range(0, 7) != 0;
            r_tk  = r_jp ? 1'b1 : 1'(($urandom_range(0, 1)));
            r_tgt = 32'h1000 + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 3) != 0) begin
                m_predict(r_epc, r_ptk, r_ptgt);
            end else begin
                r_ptk  = 1'($urandom_range(0, 1));
                r_ptgt = 32'h1000 + ($urandom_range(0, 7) << 2);
            end
            r_clr = $urandom_range(0, 49) == 0;
            cyc(r_ipc, r_v, r_epc, r_br, r_jp, r_tk, r_tgt, r_ptk, r_ptgt, r_clr);
        end

        cyc(32'h0, 1, 32'h1c0, 0, 1, 1, 32'h20, 0, 32'h1c4, 0);
        idle(32'h1c0);
        check("pre_rst_hit", {31'd0, obs_pt}, 32'd1);
        // Reset lands mid-cycle while an allocation is being presented.
        @(negedge clk);
        if_pc = 32'h1c0; ex_valid = 1; ex_pc = 32'h1d0; ex_branch = 1; ex_jump = 0;
        ex_taken = 1; ex_target = 32'h60; ex_pred_taken = 0; ex_pred_target = 32'h1d4;
        bp_clear = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pt", {31'd0, pred_taken}, 32'd0);
        check("midrst_tgt", pred_target, 32'h1c4);
        check("midrst_bcnt", branch_cnt, 32'd0);
        check("midrst_mcnt", mispred_cnt, 32'd0);
        @(negedge clk);
        ex_valid = 0;
        rst_n = 1'b1;
        m_reset();
        idle(32'h1c0);
        idle(32'h1d0);
        check("post_rst_miss", {31'd0, obs_pt}, 32'd0);
        idle(32'h140);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
